// File: rtl/bcd_range_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_range_counter_pkg
// Purpose  : Shared types and helpers for the BCD range counter.
//            bcd_digit_t - one 4-bit BCD digit
//            bcd_pair_t  - {tens, units}. The packed layout makes numeric
//                          ordering of valid BCD pairs equal to vector ordering.
//            to_bcd()    - elaboration-time decimal to BCD pair conversion
//            is_bcd()    - digit validity check (0..9)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_range_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_pair_t;

  function automatic bcd_pair_t to_bcd(input int value);
    bcd_pair_t result;
    result.tens  = 4'(value / 10);
    result.units = 4'(value % 10);
    return result;
  endfunction

  function automatic logic is_bcd(input bcd_digit_t digit);
    return (digit <= 4'd9);
  endfunction

endpackage : bcd_range_counter_pkg
`default_nettype wire

// File: rtl/bcd_range_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_range_counter_if
// Purpose  : Control/data bundle of one BCD range counter stage.
// Signals  : en, up, load    - count enable, direction, load request
//            ld1, ld0        - BCD tens/units digits to load
//            cnt1, cnt0      - registered BCD count
//            tc              - terminal count (combinational)
//            load_err        - registered flag, one cycle after a rejected load
// Modports : master - the controlling side (drives en/up/load/ld*)
//            slave  - the counter stage
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_range_counter_if;
  import bcd_range_counter_pkg::*;

  logic       en;
  logic       up;
  logic       load;
  bcd_digit_t ld1;
  bcd_digit_t ld0;
  bcd_digit_t cnt1;
  bcd_digit_t cnt0;
  logic       tc;
  logic       load_err;

  modport master (
    output en, up, load, ld1, ld0,
    input  cnt1, cnt0, tc, load_err
  );

  modport slave (
    input  en, up, load, ld1, ld0,
    output cnt1, cnt0, tc, load_err
  );

endinterface : bcd_range_counter_if
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_step
// Purpose  : Combinational single-digit BCD increment/decrement.
// Ports    : digit      in  4  current BCD digit
//            up         in  1  1 = increment, 0 = decrement
//            next_digit out 4  stepped digit (9->0 up, 0->9 down)
//            carry      out 1  carry (up) or borrow (down) out of this digit
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_step
  import bcd_range_counter_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       up,
  output bcd_digit_t next_digit,
  output logic       carry
);

  always_comb begin
    next_digit = digit;
    carry      = 1'b0;
    if (up) begin
      // >= rather than == keeps a corrupted digit from stepping into 10..15.
      if (digit >= 4'd9) begin
        next_digit = 4'd0;
        carry      = 1'b1;
      end else begin
        next_digit = digit + 4'd1;
      end
    end else begin
      if (digit == 4'd0) begin
        next_digit = 4'd9;
        carry      = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/bcd_range_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_range_counter
// Purpose  : Two-digit BCD up/down counter over the inclusive range
//            [MIN_VAL, MAX_VAL] with range-checked parallel load and a
//            combinational terminal count for cascading stages.
// Params   : MIN_VAL (0), MAX_VAL (23), RST_VAL (MIN_VAL) - decimal values
// Ports    : clk    in  rising-edge clock
//            rst_n  in  asynchronous active-low reset
//            bus    bcd_range_counter_if.slave
//                   (en, up, load, ld1, ld0 -> cnt1, cnt0, tc, load_err)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_range_counter
  import bcd_range_counter_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 23,
  parameter int RST_VAL = MIN_VAL
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_range_counter_if.slave  bus
);

  // Range limits in BCD, fixed at elaboration; all run-time comparisons
  // are made digit-wise against these.
  localparam bcd_pair_t MIN_BCD = to_bcd(MIN_VAL);
  localparam bcd_pair_t MAX_BCD = to_bcd(MAX_VAL);
  localparam bcd_pair_t RST_BCD = to_bcd(RST_VAL);

  generate
    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99) begin : g_bad_range
      $error("bcd_range_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
    end
    if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_rst
      $error("bcd_range_counter: RST_VAL outside [MIN_VAL, MAX_VAL]");
    end
  endgenerate

  bcd_pair_t  count;
  logic       load_err;

  bcd_digit_t cur_digit  [2];
  bcd_digit_t next_digit [2];
  logic [1:0] digit_carry;

  assign cur_digit[0] = count.units;
  assign cur_digit[1] = count.tens;

  // Index 0 = units, 1 = tens. Each digit steps independently; the tens
  // result is only taken when the units digit carries/borrows.
  generate
    for (genvar i = 0; i < 2; i++) begin : g_digit
      bcd_digit_step u_step (
        .digit      (cur_digit[i]),
        .up         (bus.up),
        .next_digit (next_digit[i]),
        .carry      (digit_carry[i])
      );
    end
  endgenerate

  logic      at_max;
  logic      at_min;
  logic      overflow;
  bcd_pair_t step_val;
  bcd_pair_t load_val;
  logic      load_ok;

  always_comb begin
    at_max = (count == MAX_BCD);
    at_min = (count == MIN_BCD);
    // Both digits carrying means 99 -> 00 (or 00 -> 99 down). That only
    // happens at a range boundary, so it is folded into the wrap.
    overflow = &digit_carry;

    step_val.units = next_digit[0];
    step_val.tens  = digit_carry[0] ? next_digit[1] : count.tens;
    if (bus.up && (at_max || overflow)) begin
      step_val = MIN_BCD;
    end else if (!bus.up && (at_min || overflow)) begin
      step_val = MAX_BCD;
    end

    load_val.tens  = bus.ld1;
    load_val.units = bus.ld0;
    // Vector comparison equals numeric comparison only for valid BCD, so
    // the digit checks must qualify the range checks.
    load_ok = is_bcd(bus.ld1) && is_bcd(bus.ld0) &&
              (load_val >= MIN_BCD) && (load_val <= MAX_BCD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= RST_BCD;
      load_err <= 1'b0;
    end else if (bus.load) begin
      if (load_ok) begin
        count <= load_val;
      end
      load_err <= !load_ok;
    end else begin
      load_err <= 1'b0;
      if (bus.en) begin
        count <= step_val;
      end
    end
  end

  // Combinational so a downstream stage enabled by tc advances on the
  // same edge as this stage's wrap.
  assign bus.tc       = bus.en & ~bus.load & (bus.up ? at_max : at_min);
  assign bus.cnt1     = count.tens;
  assign bus.cnt0     = count.units;
  assign bus.load_err = load_err;

endmodule : bcd_range_counter
`default_nettype wire

// File: tb/tb_bcd_range_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_range_counter
// Purpose  : Self-checking bench for bcd_range_counter.
//            a: 0..23 standalone, b: 1..12 standalone,
//            c: 0..59 whose tc enables d: 0..23.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_range_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_range_counter_if a_if ();
  bcd_range_counter_if b_if ();
  bcd_range_counter_if c_if ();
  bcd_range_counter_if d_if ();

  bcd_range_counter #(.MIN_VAL(0), .MAX_VAL(23)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  bcd_range_counter #(.MIN_VAL(1), .MAX_VAL(12)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  bcd_range_counter #(.MIN_VAL(0), .MAX_VAL(59)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));
  bcd_range_counter #(.MIN_VAL(0), .MAX_VAL(23)) u_d (.clk(clk), .rst_n(rst_n), .bus(d_if.slave));

  assign d_if.en = c_if.tc;

  int total = 0;
  int bad   = 0;

  int mins [4] = '{0, 1, 0, 0};
  int maxs [4] = '{23, 12, 59, 23};
  int model_val [4];

  typedef struct packed {
    logic [3:0] c1;
    logic [3:0] c0;
    logic       err;
    logic       tc;
  } obs_t;

  typedef struct {
    int   k;
    int   val;
    logic err;
  } exp_t;

  exp_t sbq [$];

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] l1;
    logic [3:0] l0;
    int         val;
    logic       err;
    logic       tc;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [7:0] to8(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic set_in(input int k, input logic en, input logic up, input logic load,
                        input logic [3:0] l1, input logic [3:0] l0);
    case (k)
      0: begin a_if.en = en; a_if.up = up; a_if.load = load; a_if.ld1 = l1; a_if.ld0 = l0; end
      1: begin b_if.en = en; b_if.up = up; b_if.load = load; b_if.ld1 = l1; b_if.ld0 = l0; end
      2: begin c_if.en = en; c_if.up = up; c_if.load = load; c_if.ld1 = l1; c_if.ld0 = l0; end
      default: begin d_if.up = up; d_if.load = load; d_if.ld1 = l1; d_if.ld0 = l0; end
    endcase
  endtask

  function automatic obs_t get_obs(input int k);
    obs_t o;
    case (k)
      0: o = '{a_if.cnt1, a_if.cnt0, a_if.load_err, a_if.tc};
      1: o = '{b_if.cnt1, b_if.cnt0, b_if.load_err, b_if.tc};
      2: o = '{c_if.cnt1, c_if.cnt0, c_if.load_err, c_if.tc};
      default: o = '{d_if.cnt1, d_if.cnt0, d_if.load_err, d_if.tc};
    endcase
    return o;
  endfunction

  // Reference behaviour in plain decimal.
  function automatic void model_step(input int k, input logic en, input logic up, input logic load,
                                     input logic [3:0] l1, input logic [3:0] l0,
                                     output int nv, output logic nerr, output logic ntc);
    int v;
    int ld;
    v   = model_val[k];
    ntc = en && !load && (up ? (v == maxs[k]) : (v == mins[k]));
    nv  = v;
    nerr = 1'b0;
    if (load) begin
      ld = int'(l1) * 10 + int'(l0);
      if (l1 <= 4'd9 && l0 <= 4'd9 && ld >= mins[k] && ld <= maxs[k]) nv = ld;
      else nerr = 1'b1;
    end else if (en) begin
      if (up) nv = (v == maxs[k]) ? mins[k] : v + 1;
      else    nv = (v == mins[k]) ? maxs[k] : v - 1;
    end
  endfunction

  // Called at posedge+1; drives, checks tc before the edge, then checks
  // the registered result popped from the scoreboard after the edge.
  task automatic step(input int k, input logic en, input logic up, input logic load,
                      input logic [3:0] l1, input logic [3:0] l0,
                      input int exp_val, input logic exp_err, input logic exp_tc, input string name);
    obs_t o;
    exp_t e;
    set_in(k, en, up, load, l1, l0);
    @(negedge clk);
    o = get_obs(k);
    chk({name, " tc"}, {7'd0, o.tc}, {7'd0, exp_tc});
    sbq.push_back('{k, exp_val, exp_err});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    o = get_obs(e.k);
    chk({name, " cnt"}, {o.c1, o.c0}, to8(e.val));
    chk({name, " err"}, {7'd0, o.err}, {7'd0, e.err});
  endtask

  task automatic mstep(input int k, input logic en, input logic up, input logic load,
                       input logic [3:0] l1, input logic [3:0] l0, input string name);
    int   nv;
    logic nerr;
    logic ntc;
    model_step(k, en, up, load, l1, l0, nv, nerr, ntc);
    step(k, en, up, load, l1, l0, nv, nerr, ntc, name);
    model_val[k] = nv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t o;
    exp_t e;

    // en, up, load, ld1, ld0, expected count, load_err, tc (before edge)
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd2,  22, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  23, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0,   0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  23, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  22, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 4'd2, 4'd4,  22, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  22, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'd0, 4'hA,  22, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'd1, 4'd9,  19, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  20, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  19, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 4'd2, 4'd3,  23, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 4'd1, 4'd5,  15, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  15, 1'b0, 1'b0};

    for (int k = 0; k < 4; k++) set_in(k, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_val = '{0, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      o = get_obs(k);
      chk($sformatf("reset%0d cnt", k), {o.c1, o.c0}, to8(model_val[k]));
      chk($sformatf("reset%0d err", k), {7'd0, o.err}, 8'd0);
      chk($sformatf("reset%0d tc", k), {7'd0, o.tc}, 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0..23 full up cycle with wrap
    for (int i = 0; i < 24; i++) mstep(0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, $sformatf("up%0d", i));

    // Table of loads, wraps, carries and rejected loads
    for (int i = 0; i < 14; i++) begin
      step(0, tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].l1, tbl[i].l0,
           tbl[i].val, tbl[i].err, tbl[i].tc, $sformatf("vec%0d", i));
      model_val[0] = tbl[i].val;
    end
    set_in(0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    // 1..12 counting down from reset value 1
    for (int i = 0; i < 4; i++) mstep(1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, $sformatf("dn%0d", i));
    set_in(1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    // 0..59 load, wrap and rejected loads
    mstep(2, 1'b0, 1'b1, 1'b1, 4'd5, 4'd9, "c_ld59");
    mstep(2, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, "c_wrap");
    mstep(2, 1'b0, 1'b1, 1'b1, 4'd6, 4'd0, "c_ld60");
    mstep(2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, "c_hold1");
    mstep(2, 1'b0, 1'b1, 1'b1, 4'd2, 4'hA, "c_ld2A");
    mstep(2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, "c_hold2");

    // Chain 59/23 -> 00/00 on one edge
    mstep(2, 1'b0, 1'b1, 1'b1, 4'd5, 4'd9, "ch_c59");
    set_in(2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    mstep(3, 1'b0, 1'b1, 1'b1, 4'd2, 4'd3, "ch_d23");
    set_in(3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    set_in(2, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    o = get_obs(2);
    chk("chain c tc", {7'd0, o.tc}, 8'd1);
    o = get_obs(3);
    chk("chain d tc", {7'd0, o.tc}, 8'd1);
    sbq.push_back('{2, 0, 1'b0});
    sbq.push_back('{3, 0, 1'b0});
    @(posedge clk);
    #1;
    set_in(2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = get_obs(e.k);
      chk($sformatf("chain%0d cnt", e.k), {o.c1, o.c0}, to8(e.val));
    end

    // Asynchronous reset between edges at count 17 with load_err set
    mstep(0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd7, "ar_ld17");
    mstep(0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd9, "ar_bad");
    set_in(0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    o = get_obs(0);
    chk("areset cnt", {o.c1, o.c0}, 8'h00);
    chk("areset err", {7'd0, o.err}, 8'd0);
    set_in(0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    #1;
    o = get_obs(0);
    chk("areset tc", {7'd0, o.tc}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_val[0] = 0;
    mstep(0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, "resume");
    set_in(0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd_range_counter
`default_nettype wire

// File: doc/bcd_range_counter.md
# bcd_range_counter

Two-digit BCD counter with a parameterised inclusive range [MIN_VAL, MAX_VAL], up/down direction, synchronous parallel load with BCD range checking, and a terminal-count output for cascading. It is the general counting stage for the alarm-clock datapath. Typical instances:
- hours: 0–23 or 1–12
- minutes and seconds: 0–59
- day of month: 1–31

Instances chain by driving the next stage's `en` from this stage's `tc`.

## Interface
Parameters:
- MIN_VAL, default 0: lowest count value, decimal; 0 ≤ MIN_VAL < MAX_VAL.
- MAX_VAL, default 23: highest count value, decimal; MAX_VAL ≤ 99.
- RST_VAL, default MIN_VAL: value loaded on reset; MIN_VAL ≤ RST_VAL ≤ MAX_VAL.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk upstream.
- en  in  1  count enable; one step per clk edge while high.
- up  in  1  direction: 1 counts up, 0 counts down; sampled together with en.
- load  in  1  synchronous load request; takes priority over en.
- ld1  in  4  BCD tens digit to load.
- ld0  in  4  BCD units digit to load.
- cnt1  out  4  BCD tens digit, registered.
- cnt0  out  4  BCD units digit, registered.
- tc  out  1  terminal count, combinational: en & ~load & (up ? value==MAX_VAL : value==MIN_VAL).
- load_err  out  1  registered; high for one cycle after a rejected load.

## Operation
Reset (rst_n low), asynchronous:
- {cnt1,cnt0} = BCD(RST_VAL); load_err = 0.

Priority per clock edge: load, then en, then hold.

Load:
- A load is valid when ld1 ≤ 9, ld0 ≤ 9, and MIN_VAL ≤ 10·ld1+ld0 ≤ MAX_VAL.
- Valid load: {cnt1,cnt0} ← {ld1,ld0}; load_err ← 0.
- Invalid load: count is unchanged; load_err ← 1.
- The en input is ignored in any cycle with load = 1.

Count up (en=1, up=1):
- At MAX_VAL: wrap to MIN_VAL.
- Otherwise, if cnt0 == 9: cnt0 ← 0, cnt1 ← cnt1+1.
- Otherwise: cnt0 ← cnt0+1.

Count down (en=1, up=0):
- At MIN_VAL: wrap to MAX_VAL.
- Otherwise, if cnt0 == 0: cnt0 ← 9, cnt1 ← cnt1−1.
- Otherwise: cnt0 ← cnt0−1.

Other rules:
- load_err clears on any cycle without a rejected load.
- All arithmetic is per-digit, 4 bits wide. No binary intermediate is stored.
- The outputs never hold a non-BCD code or an out-of-range value.
- The range comparisons use parameter constants converted to BCD at elaboration.

## Timing
- Count, load, and load_err update one cycle after the sampling edge.
- tc is combinational from en/load/up and the registered count. It must be valid before the next edge so a downstream stage advances on the same edge as this stage's wrap.
- Wrap and carry happen in the same cycle; there is no extra cycle at the boundary.
- A direction change takes effect on the very next enabled edge.
- Reset asserted mid-count forces RST_VAL immediately and drives tc low once en is low.
- During reset, tc still follows the equation but downstream stages are held in reset too.
- load and en together: the load wins, and tc = 0 that cycle.

## Structure
A shared package holds:
- BCD digit typedef (4 bits)
- function to_bcd(int) returning {tens,units}
- function is_bcd(digit)

Elaboration-time assertions: MIN_VAL < MAX_VAL ≤ 99; RST_VAL within range.

Sub-module: bcd_digit_step (combinational). Inputs: digit, up. Outputs: next digit, digit-carry/borrow. It is instantiated for each digit, and the top module adds the range wrap and load logic on top.

## Test plan
- Default params (0–23), reset, en=1, up=1 for 24 edges → 00,01,…,09,10,…,23,00; tc high only while count = 23.
- MIN_VAL=1, MAX_VAL=12, up=0 from RST_VAL=1 → 01→12→11→10→09; tc high only at 01; 10→09 borrows correctly.
- MIN_VAL=0, MAX_VAL=59, load ld1=5, ld0=9, then en → count 59, next 00; load of 6/0 and of 2/A → count unchanged, load_err=1 for one cycle each.
- load=1, en=1 at count 23 with ld=1,5 → count 15, tc=0 that cycle, no wrap.
- Two chained instances (0–59 feeding 0–23) preset to 59/23, one enable pulse → 00/00 on the same edge.
- rst_n pulled low asynchronously between edges at count 17 → outputs 00 immediately, load_err=0; counting resumes from 00 after release.
